// File: rtl/agc_sequencer.sv
// AGC control sequencer: fetches instruction words, latches them into IR and
// walks a fixed micro-step sequence per opcode to drive the datapath controls.
module agc_sequencer #(
    parameter logic [11:0] RESET_PC = 12'd0,
    parameter logic [2:0]  ALU_ADD  = 3'd0,
    parameter logic [2:0]  ALU_AND  = 3'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [15:0] mem_data,
    output logic [11:0] pc_addr,
    output logic [2:0]  alu_op,
    output logic [1:0]  MAddr_MUX,
    output logic [1:0]  Q_MUX,
    output logic [1:0]  A_MUX,
    output logic [1:0]  X_MUX,
    output logic [1:0]  Z_MUX,
    output logic [1:0]  Y_MUX,
    output logic        LP_MUX,
    output logic        B_MUX,
    output logic        LP_WE,
    output logic        G_WE,
    output logic        Q_WE,
    output logic        B_WE,
    output logic        A_WE,
    output logic        Y_WE,
    output logic        X_WE,
    output logic        Z_WE,
    output logic        mem_WE,
    output logic        busy,
    output logic        instr_done,
    output logic        halted
);

    typedef enum logic [2:0] {IDLE, FETCH_A, FETCH_D, E0, E1, E2, E3} state_t;

    localparam logic [2:0] OP_TC   = 3'd0;
    localparam logic [2:0] OP_CA   = 3'd1;
    localparam logic [2:0] OP_CS   = 3'd2;
    localparam logic [2:0] OP_TS   = 3'd3;
    localparam logic [2:0] OP_AD   = 3'd4;
    localparam logic [2:0] OP_MASK = 3'd5;
    localparam logic [2:0] OP_XCH  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    state_t      state_r;
    state_t      state_s;
    logic [11:0] pc_r;
    logic [15:0] ir_r;
    logic        halted_r;
    logic [2:0]  opcode_s;
    logic        last_s;
    logic        halt_set_s;
    logic        exec_s;

    assign opcode_s   = ir_r[15:13];
    assign halt_set_s = (state_r == E0) && (opcode_s == OP_HALT);
    assign exec_s     = (state_r == E0) || (state_r == E1) || (state_r == E2) || (state_r == E3);
    assign pc_addr    = pc_r;
    assign halted     = halted_r;

    // Final micro-step of the current opcode
    always_comb begin
        last_s = 1'b0;
        case (opcode_s)
            OP_TC, OP_TS, OP_HALT: last_s = (state_r == E0);
            OP_CA:                 last_s = (state_r == E1);
            OP_CS, OP_XCH:         last_s = (state_r == E2);
            OP_AD, OP_MASK:        last_s = (state_r == E3);
            default:               last_s = 1'b0;
        endcase
    end

    // Next-state and Moore control decode from (state, IR)
    always_comb begin
        state_s    = state_r;
        alu_op     = 3'd0;
        MAddr_MUX  = 2'd0;
        Q_MUX      = 2'd0;
        A_MUX      = 2'd0;
        X_MUX      = 2'd0;
        Z_MUX      = 2'd0;
        Y_MUX      = 2'd0;
        LP_MUX     = 1'b0;
        B_MUX      = 1'b0;
        LP_WE      = 1'b0;
        G_WE       = 1'b0;
        Q_WE       = 1'b0;
        B_WE       = 1'b0;
        A_WE       = 1'b0;
        Y_WE       = 1'b0;
        X_WE       = 1'b0;
        Z_WE       = 1'b0;
        mem_WE     = 1'b0;
        busy       = (state_r != IDLE);
        instr_done = 1'b0;
        case (state_r)
            IDLE: begin
                if (run && !halted_r) begin
                    state_s = FETCH_A;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH_A: begin
                MAddr_MUX = 2'd0;
                state_s   = FETCH_D;
            end
            FETCH_D: begin
                B_WE    = 1'b1;
                B_MUX   = 1'b0;
                state_s = E0;
            end
            E0: begin
                case (opcode_s)
                    OP_CA, OP_CS, OP_AD, OP_MASK, OP_XCH: MAddr_MUX = 2'd1;
                    OP_TS: begin
                        MAddr_MUX = 2'd1;
                        mem_WE    = 1'b1;
                    end
                    default: MAddr_MUX = 2'd0;
                endcase
            end
            E1: begin
                case (opcode_s)
                    OP_CA, OP_CS: begin
                        A_WE  = 1'b1;
                        A_MUX = 2'd0;
                    end
                    OP_AD, OP_MASK: begin
                        Y_WE  = 1'b1;
                        Y_MUX = 2'd0;
                        X_WE  = 1'b1;
                        X_MUX = 2'd3;
                    end
                    OP_XCH: begin
                        MAddr_MUX = 2'd1;
                        G_WE      = 1'b1;
                        mem_WE    = 1'b1;
                    end
                    default: A_WE = 1'b0;
                endcase
            end
            E2: begin
                case (opcode_s)
                    OP_CS: begin
                        A_WE  = 1'b1;
                        A_MUX = 2'd2;
                    end
                    OP_AD:   alu_op = ALU_ADD;
                    OP_MASK: alu_op = ALU_AND;
                    OP_XCH: begin
                        A_WE  = 1'b1;
                        A_MUX = 2'd3;
                    end
                    default: A_WE = 1'b0;
                endcase
            end
            E3: begin
                case (opcode_s)
                    OP_AD: begin
                        alu_op = ALU_ADD;
                        A_WE   = 1'b1;
                        A_MUX  = 2'd1;
                    end
                    OP_MASK: begin
                        alu_op = ALU_AND;
                        A_WE   = 1'b1;
                        A_MUX  = 2'd1;
                    end
                    default: A_WE = 1'b0;
                endcase
            end
            default: state_s = IDLE;
        endcase
        // Sampling run only here keeps a started instruction intact
        if (exec_s) begin
            if (last_s) begin
                instr_done = 1'b1;
                state_s    = (run && !halted_r && !halt_set_s) ? FETCH_A : IDLE;
            end else begin
                state_s = state_t'(state_r + 3'd1);
            end
        end else begin
            instr_done = 1'b0;
        end
    end

    // State, program counter, instruction register and halt flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            pc_r     <= RESET_PC;
            ir_r     <= 16'd0;
            halted_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (state_r == FETCH_D) begin
                ir_r <= mem_data;
                pc_r <= pc_r + 12'd1;
            end else if ((state_r == E0) && (opcode_s == OP_TC)) begin
                pc_r <= ir_r[12:1];
            end else begin
                pc_r <= pc_r;
            end
            if (halt_set_s) begin
                halted_r <= 1'b1;
            end else if ((state_r == IDLE) && !run) begin
                halted_r <= 1'b0;
            end else begin
                halted_r <= halted_r;
            end
        end
    end

endmodule
